// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: pipelined carry-lookahead adder/subtractor.
// One GROUP-bit lookahead group is resolved per pipeline stage. The carry
// between groups is registered, so the critical path is a single group's
// flat lookahead logic. Operand and sum slices ride alongside each
// transaction in skew registers. A single global stall signal freezes the
// whole pipeline whenever the output holds a result nobody has taken.
module pipe_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  input  logic             sub,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] s,
  output logic             cOut,
  output logic             ovf
);

  localparam int STAGES = WIDTH / GROUP;

  // Refuse to elaborate a width that does not split into whole groups.
  if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_group
    $error("pipe_cla_adder: WIDTH must be a positive multiple of GROUP");
  end

  // One pipeline slot. Slot 0 holds the captured operands (B already
  // inverted for subtraction, carry = c0). Slot k+1 holds the result of
  // lookahead group k plus the carry out of that group. Slot STAGES is
  // the output register.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } slot_t;

  // Result of one lookahead group.
  typedef struct packed {
    logic [GROUP-1:0] sum;
    logic             c_out;  // carry out of the group's top bit
    logic             c_msb;  // carry into the group's top bit
  } group_t;

  slot_t  slot_q   [STAGES+1];
  slot_t  slot_d   [STAGES+1];
  group_t grp_res  [STAGES];
  logic   advance;

  // Full carry lookahead for one group: every carry is a flat OR of
  // products of generate/propagate terms and the group carry-in; no
  // carry feeds another carry inside the group.
  function automatic group_t add_group(input logic [GROUP-1:0] ga,
                                       input logic [GROUP-1:0] gb,
                                       input logic             cin);
    logic [GROUP-1:0] gen;
    logic [GROUP-1:0] prop;
    logic [GROUP:0]   c;
    logic             term;
    group_t           res;
    gen  = ga & gb;
    prop = ga | gb;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      // Product term carrying the group carry-in all the way to bit i+1.
      term = cin;
      for (int m = 0; m <= i; m++) term = term & prop[m];
      c[i+1] = term;
      // Product terms for a carry generated at bit j and propagated to i+1.
      for (int j = 0; j <= i; j++) begin
        term = gen[j];
        for (int m = j + 1; m <= i; m++) term = term & prop[m];
        c[i+1] = c[i+1] | term;
      end
    end
    res.sum   = ga ^ gb ^ c[GROUP-1:0];
    res.c_out = c[GROUP];
    res.c_msb = c[GROUP-1];
    return res;
  endfunction

  // The pipeline moves only when the output slot is empty or being taken.
  assign advance  = !slot_q[STAGES].valid || outReady;
  assign inReady  = advance;

  assign outValid = slot_q[STAGES].valid;
  assign s        = slot_q[STAGES].sum;
  assign cOut     = slot_q[STAGES].carry;
  assign ovf      = slot_q[STAGES].ovf;

  // Next-state for every slot: capture operands, then one group per stage.
  always_comb begin
    // NOTE: every variable written here gets a value on every path first,
    // otherwise synthesis infers a latch to remember the old value.
    slot_d[0].valid = inValid;
    slot_d[0].opa   = a;
    slot_d[0].opb   = sub ? ~b : b;
    slot_d[0].sum   = '0;
    slot_d[0].carry = sub ? 1'b1 : cIn;
    slot_d[0].ovf   = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      grp_res[k] = add_group(slot_q[k].opa[k*GROUP +: GROUP],
                             slot_q[k].opb[k*GROUP +: GROUP],
                             slot_q[k].carry);
      slot_d[k+1]                         = slot_q[k];
      slot_d[k+1].sum[k*GROUP +: GROUP]   = grp_res[k].sum;
      slot_d[k+1].carry                   = grp_res[k].c_out;
      if (k == STAGES - 1) begin
        slot_d[k+1].ovf = grp_res[k].c_msb ^ grp_res[k].c_out;
      end
    end
  end

  // Pipeline registers: cleared asynchronously, frozen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath is reset along with the valid bits because the
      // output slot drives s/cOut/ovf directly and must read zero in reset.
      for (int k = 0; k <= STAGES; k++) slot_q[k] <= '0;
    end else if (advance) begin
      // NOTE: non-blocking assignment so every slot samples the old value
      // of its predecessor, giving a true shift rather than a fall-through.
      for (int k = 0; k <= STAGES; k++) slot_q[k] <= slot_d[k];
    end
  end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder at WIDTH=16, GROUP=4.
// Directed vectors from a table, hand-written stall and reset sequences,
// and a randomized handshake run against an arithmetic reference model.
module tb_pipe_cla_adder;

  localparam int W  = 16;
  localparam int G  = 4;
  localparam int ST = W / G;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         c_out;
  logic         ovf;

  always #5 clk = ~clk;

  pipe_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (in_valid),
    .inReady  (in_ready),
    .a        (a),
    .b        (b),
    .cIn      (c_in),
    .sub      (sub_op),
    .outValid (out_valid),
    .outReady (out_ready),
    .s        (s),
    .cOut     (c_out),
    .ovf      (ovf)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_s;
    logic         exp_c;
    logic         exp_v;
  } vec_t;

  res_t         model_q[$];
  logic [W-1:0] delivered[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_in     = 0;
  int           n_out    = 0;

  logic         smp_in_ready;
  logic         smp_out_valid;
  logic [W-1:0] smp_s;
  logic         smp_c;
  logic         smp_v;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit arithmetic and sign rules.
  function automatic res_t ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                     input logic rcin, input logic rsub);
    logic [W-1:0] bp;
    logic [W:0]   full;
    res_t         r;
    bp   = rsub ? ~rb : rb;
    full = {1'b0, ra} + {1'b0, bp} + {{W{1'b0}}, (rsub ? 1'b1 : rcin)};
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.v  = (ra[W-1] == bp[W-1]) && (r.s[W-1] != ra[W-1]);
    return r;
  endfunction

  // One clock cycle. Called at a falling edge with inputs already driven;
  // samples outputs, does handshake bookkeeping, returns at the next fall.
  task automatic cycle();
    res_t e;
    #1;
    smp_in_ready  = in_ready;
    smp_out_valid = out_valid;
    smp_s         = s;
    smp_c         = c_out;
    smp_v         = ovf;
    if (in_valid && in_ready) begin
      model_q.push_back(ref_model(a, b, c_in, sub_op));
      n_in++;
    end
    if (out_valid && out_ready) begin
      n_out++;
      delivered.push_back(s);
      if (model_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = model_q.pop_front();
        check("model_s", {16'd0, s}, {16'd0, e.s});
        check("model_cOut", {31'd0, c_out}, {31'd0, e.c});
        check("model_ovf", {31'd0, ovf}, {31'd0, e.v});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic dcin, input logic dsub);
    a      = da;
    b      = db;
    c_in   = dcin;
    sub_op = dsub;
  endtask

  vec_t vecs[9];

  initial begin
    int           lat;
    int           seen;
    logic         prev_hold;
    logic [W-1:0] prev_s;
    logic         prev_c;
    logic         prev_v;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h5555, 16'h5555, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

    // ---------------- reset state ----------------
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    #3;
    check("reset_outValid", {31'd0, out_valid}, 32'd0);
    check("reset_s", {16'd0, s}, 32'd0);
    check("reset_cOut", {31'd0, c_out}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check("post_reset_inReady", {31'd0, smp_in_ready}, 32'd1);

    // ---------------- directed vectors with latency ----------------
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      lat = 0;
      for (int t = 0; t < 20; t++) begin
        cycle();
        lat++;
        if (smp_out_valid) break;
      end
      check($sformatf("vec%0d_latency", i), lat, ST + 1);
      check($sformatf("vec%0d_s", i), {16'd0, smp_s}, {16'd0, vecs[i].exp_s});
      check($sformatf("vec%0d_cOut", i), {31'd0, smp_c}, {31'd0, vecs[i].exp_c});
      check($sformatf("vec%0d_ovf", i), {31'd0, smp_v}, {31'd0, vecs[i].exp_v});
    end

    // ---------------- back-to-back with output stall ----------------
    delivered.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(W'(i), W'(i), 1'b0, 1'b0);
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    // First result is now in the output register; stall it for 3 cycles
    // while offering an operand that must be refused.
    out_ready = 1'b0;
    drive(16'h0005, 16'h0005, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      cycle();
      check("stall_outValid", {31'd0, smp_out_valid}, 32'd1);
      check("stall_inReady", {31'd0, smp_in_ready}, 32'd0);
      check("stall_s_held", {16'd0, smp_s}, 32'h0002);
    end
    out_ready = 1'b1;
    cycle();
    check("release_inReady", {31'd0, smp_in_ready}, 32'd1);
    in_valid = 1'b0;
    for (int t = 0; t < 20 && model_q.size() != 0; t++) cycle();
    check("stall_drain_count", delivered.size(), 5);
    if (delivered.size() == 5) begin
      check("order_0", {16'd0, delivered[0]}, 32'h0002);
      check("order_1", {16'd0, delivered[1]}, 32'h0004);
      check("order_2", {16'd0, delivered[2]}, 32'h0006);
      check("order_3", {16'd0, delivered[3]}, 32'h0008);
      check("order_4", {16'd0, delivered[4]}, 32'h000A);
    end

    // ---------------- reset with transactions in flight ----------------
    for (int i = 0; i < 3; i++) begin
      drive(W'(16'h0100 + i), 16'h0011, 1'b0, 1'b0);
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    check("inflight_before_reset", model_q.size(), 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outValid", {31'd0, out_valid}, 32'd0);
    check("async_reset_s", {16'd0, s}, 32'd0);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      cycle();
      if (smp_out_valid) seen++;
    end
    check("no_stale_after_reset", seen, 0);
    check("inReady_after_reset", {31'd0, smp_in_ready}, 32'd1);
    drive(16'h00AA, 16'h0055, 1'b0, 1'b0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    for (int t = 0; t < 20; t++) begin
      cycle();
      lat++;
      if (smp_out_valid) break;
    end
    check("post_reset_latency", lat, ST + 1);
    check("post_reset_s", {16'd0, smp_s}, 32'h00FF);

    // ---------------- randomized handshake ----------------
    n_in      = 0;
    n_out     = 0;
    prev_hold = 1'b0;
    prev_s    = '0;
    prev_c    = 1'b0;
    prev_v    = 1'b0;
    in_valid  = 1'b0;
    for (int t = 0; t < 1500; t++) begin
      // Upstream holds its operands until they are taken.
      if (!in_valid || smp_in_ready || t == 0) begin
        drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        in_valid = ($urandom_range(3, 0) != 0);
      end
      out_ready = ($urandom_range(3, 0) != 0);
      cycle();
      if (prev_hold) begin
        check("hold_outValid", {31'd0, smp_out_valid}, 32'd1);
        check("hold_s", {16'd0, smp_s}, {16'd0, prev_s});
        check("hold_cOut", {31'd0, smp_c}, {31'd0, prev_c});
        check("hold_ovf", {31'd0, smp_v}, {31'd0, prev_v});
      end
      prev_hold = smp_out_valid && !out_ready;
      prev_s    = smp_s;
      prev_c    = smp_c;
      prev_v    = smp_v;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && model_q.size() != 0; t++) cycle();
    check("random_drain_empty", model_q.size(), 0);
    check("random_count_in_out", n_out, n_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter GROUP, default 8: carry-lookahead group width; WIDTH SHALL be an integer multiple of GROUP, and elaboration SHALL fail otherwise.
REQ-003 Derived STAGES = WIDTH/GROUP: pipeline depth, one lookahead group per stage.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 inValid  input  1  operand set on a/b/cIn/sub is valid.
REQ-007 inReady  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cIn  input  1  carry-in, used only in add mode.
REQ-011 sub  input  1  0 = A+B+cIn; 1 = A-B.
REQ-012 outValid  output  1  s/cOut/ovf hold a valid result.
REQ-013 outReady  input  1  downstream accepts the result this cycle.
REQ-014 s  output  WIDTH  sum or difference.
REQ-015 cOut  output  1  carry out of the MSB; in sub mode, 1 = no borrow.
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Effective operands: B' = sub ? ~b : b; carry-in c0 = sub ? 1 : cIn.
REQ-018 Each stage k (0..STAGES-1) SHALL compute bits [k*GROUP +: GROUP] with full carry lookahead inside the group: generate a&b', propagate a|b', and every group carry as a flat sum of products with no ripple chain.
REQ-019 Inter-stage carry SHALL be registered; stage k consumes the carry registered by stage k-1, and stage 0 consumes c0.
REQ-020 Upper operand slices not yet consumed and lower sum slices already produced SHALL travel with their transaction through per-stage skew registers.
REQ-021 Latency: a transaction accepted at edge T SHALL present outValid=1 with its result after edge T+STAGES, provided no stall occurs.
REQ-022 Handshake: input transfer occurs when inValid&&inReady; output transfer occurs when outValid&&outReady.
REQ-023 Global stall: advance = !outValid || outReady; inReady = advance; while advance=0 every stage register, including valid bits, SHALL hold.
REQ-024 Accepting a new input in the same cycle a result is delivered SHALL be allowed, giving a throughput of one transaction per cycle.
REQ-025 Empty slots (bubbles) SHALL advance with valid=0 and SHALL never raise outValid.
REQ-026 Results SHALL leave in acceptance order, with none dropped or duplicated.
REQ-027 cOut SHALL equal the carry out of bit WIDTH-1.
REQ-028 ovf SHALL equal the carry into bit WIDTH-1 XOR cOut.
REQ-029 s/cOut/ovf SHALL be stable while outValid=1 and outReady=0.
REQ-030 If inValid=1 while inReady=0, the operands SHALL be ignored; the upstream source holds them.

Reset
REQ-031 When rst=1, all valid bits SHALL clear immediately without waiting for clk, so that outValid=0 and any in-flight transactions are discarded.
REQ-032 During reset s, cOut and ovf SHALL be 0, and inReady SHALL be 1 one cycle after rst deasserts.
REQ-033 Reset asserted mid-operation SHALL leave no stale result visible after deassertion.

Verification (WIDTH=16, GROUP=4, STAGES=4)
REQ-034 a=0xFFFF, b=0x0001, cIn=0, sub=0, accepted at edge T -> at T+4: outValid=1, s=0x0000, cOut=1, ovf=0.
REQ-035 a=0x7FFF, b=0x0001, cIn=0, sub=0 -> s=0x8000, cOut=0, ovf=1; and a=0x1234, b=0x0000, cIn=1 -> s=0x1235.
REQ-036 a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cOut=1, ovf=1; and a=0x0003, b=0x0005, sub=1 -> s=0xFFFE, cOut=0, ovf=0.
REQ-037 Four back-to-back inputs (1+1, 2+2, 3+3, 4+4) with outReady=0 for 3 cycles once the first result appears -> inReady=0 during the stall; outputs 0x0002, 0x0004, 0x0006, 0x0008 in order, with the first held stable throughout the stall.
REQ-038 rst pulsed with 3 transactions in flight -> outValid=0 immediately; no result appears afterwards until a new input is accepted, which completes 4 cycles later.
REQ-039 Random stimulus with random inValid/outReady against a reference model of (a + B' + c0) mod 2^17 -> every s/cOut match, and the transaction count in equals the count out.
